hub75_scan_reader: RTL and testbench

- Read-side consumer of the 2048 x 6-bit pixel framebuffer. It continuously scans the framebuffer through its synchronous read port, which has 1-cycle latency.
- It drives a 64x32 HUB75 RGB LED panel with 1/16 scan (two half-panels shifted in parallel).
- Colour depth is 2 bits per channel, shown with 2-plane binary-coded modulation.
- The frame_start pulse lets the framebuffer writer align updates to the frame.

---
 rtl/hub75_pkg.sv | 35 +++
 rtl/hub75_show_timer.sv | 69 ++++++
 rtl/hub75_scan_reader.sv | 173 +++++++++++++++++
 tb/tb_hub75_scan_reader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 framebuffer scan reader.
//   - state_e        : scan FSM states (SHIFT -> LATCH -> SHOW)
//   - PH_*           : the four phases of one shifted column
//   - R/G/B_LSB      : colour field positions inside a 6-bit pixel
//   - DEF_*          : default panel geometry and plane-0 on-time
//   - plane_bits()   : picks the {r,g,b} bits of one bit-plane from a pixel
package hub75_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [1:0] PH_ADDR_UP = 2'd0;
  localparam logic [1:0] PH_ADDR_LO = 2'd1;
  localparam logic [1:0] PH_DATA    = 2'd2;
  localparam logic [1:0] PH_CLK     = 2'd3;

  localparam int R_LSB = 4;
  localparam int G_LSB = 2;
  localparam int B_LSB = 0;

  localparam int DEF_COLS      = 64;
  localparam int DEF_ROWS_HALF = 16;
  localparam int DEF_OE_TIME   = 256;
  localparam int DEF_ADDR_W    = 11;

  // Each channel is 2 bits wide; plane 0 shows the LSB, plane 1 the MSB.
  function automatic logic [2:0] plane_bits(input logic [5:0] pix, input logic plane);
    return plane ? {pix[R_LSB+1], pix[G_LSB+1], pix[B_LSB+1]}
                 : {pix[R_LSB],   pix[G_LSB],   pix[B_LSB]};
  endfunction

endpackage

// File: rtl/hub75_show_timer.sv
// hub75_show_timer: times the SHOW interval of one bit-plane.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   load          : 1-cycle pulse, starts a SHOW interval of OE_TIME<<plane cycles
//   plane         : bit-plane being shown (sets the binary weight)
//   bright [2:0]  : brightness, on-time is (bright+1)/8 of the interval
//   oe_n          : panel output enable, active-low
//   done          : high in the last cycle of the interval
module hub75_show_timer
  import hub75_pkg::*;
#(
  parameter int OE_TIME = DEF_OE_TIME
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       plane,
  input  logic [2:0] bright,
  output logic       oe_n,
  output logic       done
);

  localparam int CNT_W  = $clog2(2 * OE_TIME) + 1;
  localparam int PROD_W = CNT_W + 3;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              active_q, active_d;
  logic [CNT_W-1:0]  total;
  logic [PROD_W-1:0] on_len_x;
  logic [CNT_W-1:0]  on_len;

  // The counter runs down from total-1 to 0. The LEDs are lit during the
  // first on_len cycles, i.e. while the remaining count is still at or above
  // total-on_len; that threshold is latched together with the load so the
  // compare is a single magnitude check per cycle.
  always_comb begin
    total    = plane ? CNT_W'(2 * OE_TIME) : CNT_W'(OE_TIME);
    on_len_x = (PROD_W'(total) * (PROD_W'(bright) + PROD_W'(1))) >> 3;
    on_len   = on_len_x[CNT_W-1:0];
    cnt_d    = cnt_q;
    thresh_d = thresh_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = total - CNT_W'(1);
      thresh_d = total - on_len;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      thresh_q <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      thresh_q <= thresh_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (cnt_q == '0);
  assign oe_n = !(active_q && (cnt_q >= thresh_q));

endmodule

// File: rtl/hub75_scan_reader.sv
// hub75_scan_reader: scans a 2048 x 6-bit framebuffer through its 1-cycle
// latency read port and drives a 64x32, 1/16-scan HUB75 panel with 2-plane
// binary-coded modulation.
// Ports:
//   clk, rst          : clock and asynchronous active-low reset
//   rd_addr / rd_data : framebuffer read port, address {half,row,col}
//   r1,g1,b1/r2,g2,b2 : upper / lower half-panel colour bits
//   panel_clk, lat, oe_n, row_addr : HUB75 control
//   frame_start       : 1-cycle pulse on the first cycle of each frame
//   bright [2:0]      : only with HUB75_BRIGHTNESS_EN defined; otherwise full on-time
module hub75_scan_reader
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS_HALF = DEF_ROWS_HALF,
  parameter int OE_TIME   = DEF_OE_TIME,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [2:0]        bright,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_data,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic              r2,
  output logic              g2,
  output logic              b2,
  output logic              panel_clk,
  output logic              lat,
  output logic              oe_n,
  output logic [3:0]        row_addr,
  output logic              frame_start
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS_HALF);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             plane_q, plane_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       phase_q, phase_d;
  logic             lat_cnt_q, lat_cnt_d;
  logic [5:0]       up_q, up_d;
  logic [5:0]       colour_q, colour_d;
  logic [3:0]       row_addr_q, row_addr_d;
  logic [5:0]       pix_now;
  logic             timer_load;
  logic             timer_done;
  logic [2:0]       bright_w;

`ifdef HUB75_BRIGHTNESS_EN
  assign bright_w = bright;
`else
  assign bright_w = 3'd7;
`endif

  // Next-state logic. The upper pixel arrives in phase 1 and is kept in up_q;
  // the lower pixel arrives in phase 2 straight off rd_data, so the colour
  // pair is formed in phase 2 and frozen in colour_q for the clock phase.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    plane_d    = plane_q;
    col_d      = col_q;
    phase_d    = phase_q;
    lat_cnt_d  = lat_cnt_q;
    up_d       = up_q;
    colour_d   = colour_q;
    row_addr_d = row_addr_q;
    timer_load = 1'b0;
    pix_now    = {plane_bits(up_q, plane_q), plane_bits(rd_data, plane_q)};
    unique case (state_q)
      SHIFT: begin
        phase_d = phase_q + 2'd1;
        case (phase_q)
          PH_ADDR_LO: up_d     = rd_data;
          PH_DATA:    colour_d = pix_now;
          PH_CLK: begin
            if (col_q == COL_W'(COLS - 1)) begin
              col_d     = '0;
              state_d   = LATCH;
              lat_cnt_d = 1'b0;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          default: ;
        endcase
      end
      LATCH: begin
        // The row select moves only after the latch pulse, while LEDs are dark.
        if (!lat_cnt_q) begin
          lat_cnt_d  = 1'b1;
          row_addr_d = 4'(row_q);
        end else begin
          timer_load = 1'b1;
          state_d    = SHOW;
        end
      end
      SHOW: begin
        if (timer_done) begin
          state_d = SHIFT;
          if (plane_q) begin
            plane_d = 1'b0;
            row_d   = row_q + ROW_W'(1);
          end else begin
            plane_d = 1'b1;
          end
        end
      end
      default: state_d = SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SHIFT;
      row_q      <= '0;
      plane_q    <= 1'b0;
      col_q      <= '0;
      phase_q    <= PH_ADDR_UP;
      lat_cnt_q  <= 1'b0;
      up_q       <= '0;
      colour_q   <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      lat_cnt_q  <= lat_cnt_d;
      up_q       <= up_d;
      colour_q   <= colour_d;
      row_addr_q <= row_addr_d;
    end
  end

  hub75_show_timer #(
    .OE_TIME (OE_TIME)
  ) u_show_timer (
    .clk    (clk),
    .rst_n  (rst),
    .load   (timer_load),
    .plane  (plane_q),
    .bright (bright_w),
    .oe_n   (oe_n),
    .done   (timer_done)
  );

  // The lower half-panel lives ROWS_HALF rows further on, i.e. the address MSB.
  assign rd_addr = ADDR_W'({(state_q == SHIFT) && (phase_q == PH_ADDR_LO), row_q, col_q});

  // Colour bits follow the freshly read pair during phase 2 so they are
  // already settled when panel_clk rises in phase 3.
  assign {r1, g1, b1, r2, g2, b2} =
    ((state_q == SHIFT) && (phase_q == PH_DATA)) ? pix_now : colour_q;

  assign panel_clk = (state_q == SHIFT) && (phase_q == PH_CLK);
  assign lat       = (state_q == LATCH) && !lat_cnt_q;
  assign row_addr  = row_addr_q;

  // Gated by rst so the pulse appears in the very first cycle after release
  // but never while reset is held.
  assign frame_start = rst && (state_q == SHIFT) && (row_q == '0) && !plane_q &&
                       (col_q == '0) && (phase_q == PH_ADDR_UP);

endmodule

// File: tb/tb_hub75_scan_reader.sv
// tb_hub75_scan_reader: directed bench for hub75_scan_reader with a
// framebuffer model behind the 1-cycle read port. One frame and a bit is
// recorded cycle by cycle, then checked against hand-derived timing.
module tb_hub75_scan_reader;

  localparam int FRAME = 20544;
  localparam int ROWP  = 1284;
  localparam int N     = FRAME + 300;
`ifdef HUB75_BRIGHTNESS_EN
  localparam int ON0 = 128;
  localparam int ON1 = 256;
  logic [2:0] bright;
`else
  localparam int ON0 = 256;
  localparam int ON1 = 512;
`endif

  logic        clk;
  logic        rst;
  logic [10:0] rd_addr;
  logic [5:0]  rd_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic        panel_clk, lat, oe_n, frame_start;
  logic [3:0]  row_addr;

  logic [5:0]  fb [2048];

  logic [5:0]  col_s  [N];
  logic        pclk_s [N];
  logic        lat_s  [N];
  logic        oe_s   [N];
  logic        fs_s   [N];
  logic [3:0]  ra_s   [N];
  logic [10:0] addr_s [N];

  int checks = 0;
  int errors = 0;

  hub75_scan_reader dut (
    .clk         (clk),
    .rst         (rst),
`ifdef HUB75_BRIGHTNESS_EN
    .bright      (bright),
`endif
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .r1          (r1),
    .g1          (g1),
    .b1          (b1),
    .r2          (r2),
    .g2          (g2),
    .b2          (b2),
    .panel_clk   (panel_clk),
    .lat         (lat),
    .oe_n        (oe_n),
    .row_addr    (row_addr),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Framebuffer model: synchronous read, data valid one cycle after address.
  always @(posedge clk) rd_data <= fb[rd_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input int cycles);
    @(negedge clk);
    rst = rst_v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic captureCycle(input int k);
    col_s[k]  = {r1, g1, b1, r2, g2, b2};
    pclk_s[k] = panel_clk;
    lat_s[k]  = lat;
    oe_s[k]   = oe_n;
    fs_s[k]   = frame_start;
    ra_s[k]   = row_addr;
    addr_s[k] = rd_addr;
  endtask

  initial begin
    int s, rises, lats, lows, first_low, fs_cnt, bad;
    rst     = 1'b0;
    rd_data = '0;
`ifdef HUB75_BRIGHTNESS_EN
    bright  = 3'd3;
`endif
    for (int i = 0; i < 2048; i++) fb[i] = '0;
    fb[0]    = 6'b110000;
    fb[1024] = 6'b000010;
    fb[1]    = 6'b011011;
    fb[1025] = 6'b100100;

    // Reset values while reset is held.
    applyStimulus(1'b0, 3);
    checkOutput("rst_rd_addr", 32'(rd_addr), 0);
    checkOutput("rst_colour", 32'({r1, g1, b1, r2, g2, b2}), 0);
    checkOutput("rst_panel_clk", 32'(panel_clk), 0);
    checkOutput("rst_lat", 32'(lat), 0);
    checkOutput("rst_oe_n", 32'(oe_n), 1);
    checkOutput("rst_row_addr", 32'(row_addr), 0);
    checkOutput("rst_frame_start", 32'(frame_start), 0);

    // Release and record a full frame plus the start of the next one.
    @(negedge clk);
    rst = 1'b1;
    #1;
    captureCycle(0);
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      captureCycle(k);
    end

    checkOutput("fs_after_release", 32'(fs_s[0]), 1);
    fs_cnt = 0;
    for (int k = 1; k < FRAME; k++) if (fs_s[k]) fs_cnt++;
    checkOutput("fs_none_mid_frame", 32'(fs_cnt), 0);
    checkOutput("fs_next_frame", 32'(fs_s[FRAME]), 1);

    checkOutput("addr_k0", 32'(addr_s[0]), 0);
    checkOutput("addr_k1", 32'(addr_s[1]), 1024);
    checkOutput("addr_k4", 32'(addr_s[4]), 1);
    checkOutput("addr_k5", 32'(addr_s[5]), 1025);
    checkOutput("addr_row15_col63_up", 32'(addr_s[15*ROWP + 252]), 1023);
    checkOutput("addr_row15_col63_lo", 32'(addr_s[15*ROWP + 253]), 2047);

    checkOutput("colour_p0_col0", 32'(col_s[3]), 32'b100000);
    checkOutput("colour_p1_col0", 32'(col_s[514+3]), 32'b100001);
    checkOutput("colour_p0_col1_ph2", 32'(col_s[6]), 32'b101010);
    checkOutput("colour_p0_col1_ph3", 32'(col_s[7]), 32'b101010);
    checkOutput("colour_p1_col1", 32'(col_s[514+7]), 32'b011100);

    // Per row and plane: shift count, latch pulse, show window, row select.
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 2; p++) begin
        s = r*ROWP + p*514;
        rises = 0; lats = 0; lows = 0; first_low = -1;
        for (int k = s; k < s + (p ? 770 : 514); k++) begin
          if (pclk_s[k] && (k == 0 || !pclk_s[k-1])) rises++;
          if (lat_s[k]) lats++;
          if (!oe_s[k]) begin
            lows++;
            if (first_low < 0) first_low = k - s;
          end
        end
        checkOutput($sformatf("rises_r%0d_p%0d", r, p), 32'(rises), 64);
        checkOutput($sformatf("lat_at_r%0d_p%0d", r, p), 32'(lat_s[s+256]), 1);
        checkOutput($sformatf("lat_cnt_r%0d_p%0d", r, p), 32'(lats), 1);
        checkOutput($sformatf("oe_low_r%0d_p%0d", r, p), 32'(lows), p ? ON1 : ON0);
        checkOutput($sformatf("oe_first_r%0d_p%0d", r, p), 32'(first_low), 258);
        checkOutput($sformatf("row_pre_r%0d_p%0d", r, p), 32'(ra_s[s+256]),
                    (p == 1) ? r : ((r == 0) ? 0 : r - 1));
        checkOutput($sformatf("row_set_r%0d_p%0d", r, p), 32'(ra_s[s+257]), r);
      end
    end
    checkOutput("row_wrap_pre", 32'(ra_s[FRAME+256]), 15);
    checkOutput("row_wrap_set", 32'(ra_s[FRAME+257]), 0);

    bad = 0;
    for (int k = 1; k < N; k++) begin
      if (!oe_s[k] && (lat_s[k] || pclk_s[k])) bad++;
      if (ra_s[k] != ra_s[k-1] && !lat_s[k-1]) bad++;
    end
    checkOutput("no_overlap_or_stray_row", 32'(bad), 0);

    // Reset in the middle of SHOW of row 7 on the second frame.
    for (int k = N; k <= FRAME + 7*ROWP + 358; k++) @(negedge clk);
    checkOutput("pre_rst_oe_n", 32'(oe_n), 0);
    checkOutput("pre_rst_row_addr", 32'(row_addr), 7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_oe_n", 32'(oe_n), 1);
    checkOutput("async_rst_row_addr", 32'(row_addr), 0);
    checkOutput("async_rst_rd_addr", 32'(rd_addr), 0);
    checkOutput("async_rst_frame_start", 32'(frame_start), 0);

    applyStimulus(1'b0, 2);
    rst = 1'b1;
    #1;
    captureCycle(0);
    for (int k = 1; k < 600; k++) begin
      @(negedge clk);
      captureCycle(k);
    end
    checkOutput("restart_fs", 32'(fs_s[0]), 1);
    checkOutput("restart_colour", 32'(col_s[3]), 32'b100000);
    checkOutput("restart_lat", 32'(lat_s[256]), 1);
    checkOutput("restart_row_addr", 32'(ra_s[257]), 0);
    checkOutput("restart_oe_on", 32'(oe_s[258]), 0);
    checkOutput("restart_plane1_colour", 32'(col_s[517]), 32'b100001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
